// File: rtl/ma_pkg.sv
// rtl/ma_pkg.sv - shared moving-average datapath constants and saturation helper
package ma_pkg;

  localparam int IN_W    = 12;
  localparam int OUT_W   = 8;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  // Clamp a signed IN_W-bit filter sample into the signed OUT_W-bit range
  function automatic logic [OUT_W-1:0] sat_sample(input logic signed [IN_W-1:0] x);
    int v;
    v = int'(x);
    if (v > SAT_MAX) return OUT_W'(SAT_MAX);
    if (v < SAT_MIN) return OUT_W'(SAT_MIN);
    return x[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/ma_fifo.sv
// rtl/ma_fifo.sv - synchronous FIFO with occupancy count and zeroed head when empty
module ma_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_head,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_level = r_level;

  // A pop on an empty FIFO is ignored; a push into a full FIFO is only legal
  // when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  // Head reads zero when empty so stale, unreset storage never leaks out
  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; contents need no reset because level gates visibility
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and level bookkeeping; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LW'(1);
    end
  end

endmodule

// File: rtl/ma_out_buffer.sv
// rtl/ma_out_buffer.sv - saturate, decimate and buffer moving-average output samples
module ma_out_buffer
  import ma_pkg::*;
#(
  parameter int DECIM = 4,
  parameter int DEPTH = 4,
  localparam int LW   = $clog2(DEPTH + 1),
  localparam int DCW  = (DECIM > 1) ? $clog2(DECIM) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [LW-1:0]    level,
  output logic             overflow
);

  logic [DCW-1:0]   r_dcnt;
  logic             r_overflow;
  logic [OUT_W-1:0] w_sat;
  logic             w_keep;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;

  assign w_sat     = sat_sample($signed(in_data));
  assign w_keep    = in_valid && (r_dcnt == '0);
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  assign w_drop    = w_keep && w_full && !w_pop;
  assign overflow  = r_overflow;

  // Decimation counter advances only on valid samples and wraps at DECIM-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dcnt <= '0;
    end else if (in_valid) begin
      if (r_dcnt == DCW'(DECIM - 1)) r_dcnt <= '0;
      else                           r_dcnt <= r_dcnt + DCW'(1);
    end
  end

  // Sticky overflow: a kept sample found the FIFO full with nothing leaving
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  ma_fifo #(
    .DEPTH (DEPTH),
    .W     (OUT_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_push  (w_keep),
    .i_pop   (w_pop),
    .i_data  (w_sat),
    .o_head  (out_data),
    .o_level (level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_ma_out_buffer.sv
// tb/tb_ma_out_buffer.sv - directed self-checking bench for ma_out_buffer
module tb_ma_out_buffer;

  logic clk = 1'b0;
  logic reset;

  // DUT A: DECIM=1
  logic        a_in_valid, a_out_ready, a_out_valid, a_overflow;
  logic [11:0] a_in_data;
  logic [7:0]  a_out_data;
  logic [2:0]  a_level;
  // DUT B: DECIM=4
  logic        b_in_valid, b_out_ready, b_out_valid, b_overflow;
  logic [11:0] b_in_data;
  logic [7:0]  b_out_data;
  logic [2:0]  b_level;
  // DUT C: DECIM=2
  logic        c_in_valid, c_out_ready, c_out_valid, c_overflow;
  logic [11:0] c_in_data;
  logic [7:0]  c_out_data;
  logic [2:0]  c_level;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ma_out_buffer #(.DECIM(1), .DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .level(a_level), .overflow(a_overflow)
  );

  ma_out_buffer #(.DECIM(4), .DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .level(b_level), .overflow(b_overflow)
  );

  ma_out_buffer #(.DECIM(2), .DEPTH(4)) u_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .level(c_level), .overflow(c_overflow)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input int d, input logic rdy);
    a_in_valid  = 1'b1;
    a_in_data   = 12'(d);
    a_out_ready = rdy;
    tick();
    a_in_valid  = 1'b0;
  endtask

  task automatic a_reset();
    #2 reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
  endtask

  int sat_in  [5] = '{600, -700, 127, -128, -5};
  int sat_exp [5] = '{127, -128, 127, -128, -5};
  logic c_vld [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int   c_exp [7] = '{10, 0, 0, 0, 14, 0, 0};

  initial begin
    reset = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    c_in_valid = 0; c_in_data = '0; c_out_ready = 0;
    #1;
    tick();

    // Reset state
    check("rst_valid",    int'(a_out_valid), 0);
    check("rst_level",    int'(a_level), 0);
    check("rst_data",     int'(a_out_data), 0);
    check("rst_overflow", int'(a_overflow), 0);
    reset = 1'b0;
    tick();

    // Saturation, one cycle latency, out_ready held high
    for (int i = 0; i < 5; i++) begin
      a_push(sat_in[i], 1'b1);
      check($sformatf("sat_data%0d", i), int'($signed(a_out_data)), sat_exp[i]);
      check($sformatf("sat_valid%0d", i), int'(a_out_valid), 1);
      check($sformatf("sat_level%0d", i), int'(a_level), 1);
    end
    tick();
    check("sat_drained_level", int'(a_level), 0);
    check("sat_drained_data", int'(a_out_data), 0);

    // Decimation by 4 on a continuous stream
    b_out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 12'(i);
      tick();
      check($sformatf("dec_valid%0d", i), int'(b_out_valid), (i % 4 == 0) ? 1 : 0);
      check($sformatf("dec_data%0d", i), int'(b_out_data), (i % 4 == 0) ? i : 0);
      check($sformatf("dec_level_max%0d", i), int'(b_level <= 3'd1), 1);
    end
    b_in_valid = 1'b0;

    // Gapped input with DECIM=2
    c_out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      c_in_valid = c_vld[i];
      c_in_data  = 12'(10 + i);
      tick();
      check($sformatf("gap_valid%0d", i), int'(c_out_valid), (c_exp[i] != 0) ? 1 : 0);
      check($sformatf("gap_data%0d", i), int'(c_out_data), c_exp[i]);
    end
    c_in_valid = 1'b0;

    // Fill and overflow with the consumer stalled
    for (int i = 1; i <= 6; i++) begin
      a_push(i, 1'b0);
      check($sformatf("fill_level%0d", i), int'(a_level), (i < 4) ? i : 4);
      check($sformatf("fill_ovf%0d", i), int'(a_overflow), (i >= 5) ? 1 : 0);
      check($sformatf("fill_head_stable%0d", i), int'(a_out_data), 1);
    end
    a_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_data%0d", i), int'(a_out_data), i);
      tick();
    end
    check("drain_level", int'(a_level), 0);
    check("drain_valid", int'(a_out_valid), 0);
    check("drain_ovf_sticky", int'(a_overflow), 1);

    // Full FIFO with simultaneous push and pop
    a_reset();
    check("fwp_ovf_cleared", int'(a_overflow), 0);
    for (int i = 1; i <= 4; i++) a_push(i, 1'b0);
    check("fwp_full_level", int'(a_level), 4);
    check("fwp_head_before", int'(a_out_data), 1);
    a_push(9, 1'b1);
    check("fwp_level", int'(a_level), 4);
    check("fwp_ovf", int'(a_overflow), 0);
    begin
      int order [4] = '{2, 3, 4, 9};
      for (int i = 0; i < 4; i++) begin
        check($sformatf("fwp_order%0d", i), int'(a_out_data), order[i]);
        tick();
      end
    end
    check("fwp_empty", int'(a_level), 0);

    // Asynchronous reset mid-stream with level=3 and overflow set
    a_out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) a_push(20 + i, 1'b0);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    check("mid_level3", int'(a_level), 3);
    check("mid_ovf_set", int'(a_overflow), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", int'(a_out_valid), 0);
    check("mid_rst_level", int'(a_level), 0);
    check("mid_rst_ovf", int'(a_overflow), 0);
    check("mid_rst_data", int'(a_out_data), 0);
    tick();
    reset = 1'b0;
    a_push(33, 1'b0);
    check("post_rst_valid", int'(a_out_valid), 1);
    check("post_rst_data", int'(a_out_data), 33);
    check("post_rst_level", int'(a_level), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ma_out_buffer.md
MA_OUT_BUFFER -- requirements
Module: ma_out_buffer

Interface
REQ-001 SHALL have parameter DECIM, default 4, giving the decimation factor (legal range 1..16).
REQ-002 SHALL have parameter DEPTH, default 4, giving the FIFO depth in entries (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, which marks in_data as a new filter output sample this cycle.
REQ-006 SHALL have port in_data, input, 12, carrying the signed filtered sample from the moving-average stage.
REQ-007 SHALL have port out_valid, output, 1, which is high when out_data holds a buffered sample.
REQ-008 SHALL have port out_ready, input, 1, asserted when the consumer accepts out_data this cycle.
REQ-009 SHALL have port out_data, output, 8, carrying the signed saturated, decimated sample at the FIFO head.
REQ-010 SHALL have port level, output, clog2(DEPTH+1), giving the current FIFO occupancy.
REQ-011 SHALL have port overflow, output, 1, a sticky flag meaning a kept sample was dropped because the FIFO was full.

Function
REQ-012 SHALL saturate in_data to 8 bits signed: values above +127 give +127, values below -128 give -128, and all other values pass unchanged (bits [7:0]).
REQ-013 SHALL keep a decimation counter dcnt, range 0..DECIM-1, that advances only on cycles where in_valid=1 and wraps DECIM-1 -> 0.
REQ-014 SHALL treat a sample as kept when in_valid=1 and dcnt=0; with in_valid=0, dcnt holds and no push occurs.
REQ-015 SHALL keep every valid sample and leave dcnt fixed at 0 when DECIM=1.
REQ-016 SHALL push a kept sample when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-017 SHALL drop a kept sample arriving when full with no pop, set overflow=1, and leave FIFO contents unchanged.
REQ-018 SHALL define a pop as out_valid=1 and out_ready=1 in the same cycle.
REQ-019 SHALL drive out_valid = (level != 0), and out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 SHALL have a latency of 1 clk from the kept-sample edge to out_valid=1 with that sample on out_data, when the FIFO starts empty.
REQ-021 SHALL, on simultaneous push and pop, leave level unchanged and preserve ordering (strict FIFO).
REQ-022 SHALL ignore out_ready when empty, with no underflow and no pointer movement.
REQ-023 SHALL wrap read and write pointers modulo DEPTH, with full/empty derived from level.
REQ-024 SHALL keep overflow sticky once set, clearable only by reset.

Reset
REQ-025 SHALL, while reset=1, asynchronously force dcnt=0, both pointers=0, level=0, out_valid=0, out_data=0, and overflow=0.
REQ-026 SHALL discard all FIFO contents on reset asserted mid-operation, with the first valid sample after release kept (dcnt=0).
REQ-027 SHALL NOT require the storage array to be reset; out_data SHALL read 0 whenever level=0.

Structure
REQ-028 SHALL take constants IN_W=12, OUT_W=8, SAT_MAX=127, and SAT_MIN=-128 from shared package ma_pkg, used also by the filter stage.
REQ-029 SHALL instantiate a single sub-module ma_fifo (parameter DEPTH, 8-bit data, push/pop/level/head) and keep saturation and decimation in the top.

Verification
REQ-030 SHALL verify saturation: DECIM=1, in_data = +600, -700, +127, -128, -5, out_ready=1 -> out_data = 127, -128, 127, -128, -5, each 1 cycle after input.
REQ-031 SHALL verify decimation: DECIM=4, in_valid=1 continuously with in_data = 0,1,2,...,11 -> out_data sequence 0, 4, 8 and level never above 1.
REQ-032 SHALL verify gapped input: DECIM=2, in_valid pattern 1,0,0,1,1,0,1 with data 10..16 -> kept samples 10 and 14 only.
REQ-033 SHALL verify fill/overflow: DECIM=1, DEPTH=4, out_ready=0, 6 samples 1..6 -> level=4, overflow=1 after sample 5; then out_ready=1 drains 1, 2, 3, 4.
REQ-034 SHALL verify the full-with-pop case: FIFO full holding 1..4, push 9 with out_ready=1 -> pops 1, level stays 4, overflow stays 0, final order 2, 3, 4, 9.
REQ-035 SHALL verify reset mid-stream: level=3, assert reset for 1 cycle asynchronously -> out_valid=0, level=0, overflow=0 immediately, and the next valid sample appears 1 cycle later.
